// File: rtl/display_clocks_pkg.sv
// Shared types and constants for the display MMCM DRP reconfiguration logic.
package display_clocks_pkg;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 16;
    localparam int RST_HOLD = 4;

    localparam logic [3:0] MODE_640X480  = 4'd0;
    localparam logic [3:0] MODE_1280X720 = 4'd1;

    typedef enum logic [3:0] {
        IDLE,
        RST_ASSERT,
        READ,
        WAIT_RD,
        WRITE,
        WAIT_WR,
        NEXT,
        RELEASE,
        WAIT_LOCK,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } drp_entry_t;

    // Bits set in keep retain the value read back from the MMCM.
    function automatic logic [DATA_W-1:0] drp_merge(
        input logic [DATA_W-1:0] i_rd,
        input drp_entry_t        i_e
    );
        return (i_rd & i_e.keep) | (i_e.data & ~i_e.keep);
    endfunction

endpackage

// File: rtl/display_clocks_drp_rom.sv
// Per-mode MMCM DRP register table: CLKOUT0/1, CLKFBOUT, DIVCLK, lock, filter.
module display_clocks_drp_rom
    import display_clocks_pkg::*;
#(
    parameter int MODE_W = 4,
    parameter int IDX_W  = 4
) (
    input  logic [MODE_W-1:0] i_mode,
    input  logic [IDX_W-1:0]  i_idx,
    output drp_entry_t        o_entry
);

    logic w_m1;
    assign w_m1 = (i_mode == MODE_W'(MODE_1280X720));

    always_comb begin
        o_entry = '{addr: '0, keep: 16'hFFFF, data: 16'h0000};
        case (int'(i_idx))
            0:  o_entry = '{7'h08, 16'h1000, w_m1 ? 16'h0145 : 16'h0659};
            1:  o_entry = '{7'h09, 16'hFC00, 16'h0000};
            2:  o_entry = '{7'h0A, 16'h1000, w_m1 ? 16'h0041 : 16'h0145};
            3:  o_entry = '{7'h0B, 16'hFC00, 16'h0000};
            4:  o_entry = '{7'h14, 16'h1000, w_m1 ? 16'h04D2 : 16'h081F};
            5:  o_entry = '{7'h15, 16'h8000, w_m1 ? 16'h1880 : 16'h0080};
            6:  o_entry = '{7'h16, 16'hC000, 16'h20C2};
            7:  o_entry = '{7'h18, 16'hFC00, w_m1 ? 16'h01E8 : 16'h00FA};
            8:  o_entry = '{7'h19, 16'h8000, 16'h7C01};
            9:  o_entry = '{7'h1A, 16'h8000, 16'h7DE9};
            10: o_entry = '{7'h4E, 16'h66FF, w_m1 ? 16'h1900 : 16'h0800};
            11: o_entry = '{7'h4F, 16'h666F, 16'h0100};
            default: ;
        endcase
    end

endmodule

// File: rtl/display_clocks_drp_ctrl.sv
// Display MMCM runtime reconfiguration sequencer: holds RST, read-modify-writes
// the per-mode DRP table, releases RST and waits for LOCKED.
module display_clocks_drp_ctrl
    import display_clocks_pkg::*;
#(
    parameter int MODE_CNT      = 2,
    parameter int MODE_W        = 4,
    parameter int REGS_PER_MODE = 12,
    parameter int DRDY_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mode_req,
    input  logic [MODE_W-1:0] i_mode,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [MODE_W-1:0] o_mode_cur,
    output logic              o_mmcm_rst,
    input  logic              i_mmcm_locked,
    output logic              o_drp_den,
    output logic              o_drp_dwe,
    output logic [6:0]        o_drp_daddr,
    output logic [15:0]       o_drp_di,
    input  logic [15:0]       i_drp_do,
    input  logic              i_drp_drdy
);

    localparam int IDX_W = (REGS_PER_MODE > 1) ? $clog2(REGS_PER_MODE) : 1;
    localparam int CNT_W = 16;

    state_t              r_state, w_state_nxt;
    logic [MODE_W-1:0]   r_mode, r_mode_cur;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mmcm_rst, w_mmcm_rst_nxt;
    logic                r_error, w_error_nxt;
    logic                r_lock_s1, r_lock_s2;
    logic                w_latch, w_capture, w_fail, w_mode_ok;
    drp_entry_t          w_entry;

    display_clocks_drp_rom #(
        .MODE_W(MODE_W),
        .IDX_W (IDX_W)
    ) u_rom (
        .i_mode (r_mode),
        .i_idx  (r_idx),
        .o_entry(w_entry)
    );

    assign w_mode_ok = int'(i_mode) < MODE_CNT;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_mmcm_rst_nxt = r_mmcm_rst;
        w_error_nxt    = r_error;
        w_latch        = 1'b0;
        w_capture      = 1'b0;
        w_fail         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_mode_req && w_mode_ok) begin
                    w_latch        = 1'b1;
                    w_idx_nxt      = '0;
                    w_error_nxt    = 1'b0;
                    w_mmcm_rst_nxt = 1'b1;
                    w_state_nxt    = RST_ASSERT;
                end else if (i_mode_req) begin
                    w_error_nxt = 1'b1;
                end
            end
            RST_ASSERT: begin
                if (int'(r_cnt) >= RST_HOLD - 1) w_state_nxt = READ;
            end
            READ: w_state_nxt = WAIT_RD;
            WAIT_RD: begin
                if (i_drp_drdy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = WRITE;
                end else if (int'(r_cnt) >= DRDY_TIMEOUT - 1) begin
                    w_fail = 1'b1;
                end
            end
            WRITE: w_state_nxt = WAIT_WR;
            WAIT_WR: begin
                if (i_drp_drdy) w_state_nxt = NEXT;
                else if (int'(r_cnt) >= DRDY_TIMEOUT - 1) w_fail = 1'b1;
            end
            NEXT: begin
                if (r_idx == IDX_W'(REGS_PER_MODE - 1)) begin
                    w_state_nxt = RELEASE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = READ;
                end
            end
            RELEASE: begin
                w_mmcm_rst_nxt = 1'b0;
                w_state_nxt    = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (r_lock_s2) w_state_nxt = DONE;
                else if (int'(r_cnt) >= LOCK_TIMEOUT - 1) w_fail = 1'b1;
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_fail) begin
            w_error_nxt    = 1'b1;
            w_mmcm_rst_nxt = 1'b0;
            w_state_nxt    = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= RELEASE;
            r_mode     <= '0;
            r_mode_cur <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_mmcm_rst <= 1'b1;
            r_error    <= 1'b0;
            r_lock_s1  <= 1'b0;
            r_lock_s2  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_mmcm_rst <= w_mmcm_rst_nxt;
            r_error    <= w_error_nxt;
            r_lock_s1  <= i_mmcm_locked;
            r_lock_s2  <= r_lock_s1;
            if (w_latch) r_mode <= i_mode;
            if (w_capture) r_rdata <= i_drp_do;
            if (r_state == DONE) r_mode_cur <= r_mode;
            // One counter serves all waits; it restarts on every state change.
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_error     = r_error;
    assign o_mode_cur  = r_mode_cur;
    assign o_mmcm_rst  = r_mmcm_rst;
    assign o_drp_den   = (r_state == READ) || (r_state == WRITE);
    assign o_drp_dwe   = (r_state == WRITE);
    assign o_drp_daddr = o_drp_den ? w_entry.addr : '0;
    assign o_drp_di    = o_drp_dwe ? drp_merge(r_rdata, w_entry) : '0;

endmodule

// File: tb/tb_display_clocks_drp_ctrl.sv
// Self-checking bench for display_clocks_drp_ctrl with DRP and MMCM lock models.
module tb_display_clocks_drp_ctrl;

    localparam int LOCK_TO  = 200;
    localparam int LOCK_DLY = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_req;
    logic [3:0]  mode;
    logic        busy, done, error;
    logic [3:0]  mode_cur;
    logic        mmcm_rst;
    logic        locked;
    logic        den, dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] drp_do;
    logic        drdy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic        chk;
        logic [15:0] data;
    } drp_op_t;
    drp_op_t sbq[$];

    typedef struct {
        logic       req;
        logic [3:0] mode;
        logic       err;
        logic       busy;
        logic       mrst;
        logic [3:0] cur;
    } vec_t;
    vec_t vecs[6];

    logic [6:0]  addr_map[12];
    logic [15:0] mem[128];
    logic        drdy_en;
    logic        lock_en;
    int          pend;
    int          lk_cnt;
    logic [15:0] rd_val;

    always #5 clk = ~clk;

    display_clocks_drp_ctrl #(
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode_req   (mode_req),
        .i_mode       (mode),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_mode_cur   (mode_cur),
        .o_mmcm_rst   (mmcm_rst),
        .i_mmcm_locked(locked),
        .o_drp_den    (den),
        .o_drp_dwe    (dwe),
        .o_drp_daddr  (daddr),
        .o_drp_di     (di),
        .i_drp_do     (drp_do),
        .i_drp_drdy   (drdy)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // DRP slave: drdy three cycles after den; every den is checked against the scoreboard.
    always @(negedge clk) begin
        drp_op_t op;
        drdy = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drdy   = 1'b1;
                drp_do = rd_val;
            end
        end
        if (den) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_den: got addr %0h we %0b expected no access", daddr, dwe);
            end else begin
                op = sbq.pop_front();
                check("drp_we", 32'(dwe), 32'(op.we));
                check("drp_addr", 32'(daddr), 32'(op.addr));
                check("mmcm_rst_during_drp", 32'(mmcm_rst), 32'd1);
                if (op.chk) check("drp_wdata", 32'(di), 32'(op.data));
            end
            if (dwe) mem[daddr] = di;
            else rd_val = mem[daddr];
            if (drdy_en) pend = 3;
        end
    end

    // MMCM model: LOCKED rises LOCK_DLY cycles after RST falls.
    always @(negedge clk) begin
        if (mmcm_rst) begin
            lk_cnt = 0;
            locked = 1'b0;
        end else if (lock_en) begin
            if (lk_cnt < LOCK_DLY) lk_cnt++;
            else locked = 1'b1;
        end
    end

    task automatic push_seq(input logic [3:0] m, input int n_ops);
        drp_op_t op;
        for (int i = 0; i < 12; i++) begin
            op = '{we: 1'b0, addr: addr_map[i], chk: 1'b0, data: 16'h0};
            if (2 * i < n_ops) sbq.push_back(op);
            op.we  = 1'b1;
            op.chk = (m == 4'd1) && (i == 0);
            op.data = 16'h1145;
            if (2 * i + 1 < n_ops) sbq.push_back(op);
        end
    endtask

    task automatic do_req(input logic [3:0] m, input int n_ops);
        @(negedge clk);
        if (m == 4'd1) mem[8] = 16'hFFFF;
        push_seq(m, n_ops);
        mode_req = 1'b1;
        mode     = m;
        @(negedge clk);
        mode_req = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        addr_map = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15,
                     7'h16, 7'h18, 7'h19, 7'h1A, 7'h4E, 7'h4F};
        vecs[0] = '{1'b1, 4'd5,  1'b1, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0};
        vecs[2] = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 4'd0};
        vecs[3] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[4] = '{1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 4'd0};
        vecs[5] = '{1'b1, 4'd1,  1'b0, 1'b1, 1'b1, 4'd0};
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        drdy_en = 1'b1; lock_en = 1'b1; pend = 0; lk_cnt = 0;
        drdy = 1'b0; drp_do = 16'h0; locked = 1'b0; rd_val = 16'h0;
        mode_req = 1'b0; mode = 4'd0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_mode_cur", 32'(mode_cur), 32'd0);
        check("rst_drp", {15'd0, den, dwe, daddr, 7'd0}, 32'd0);
        check("rst_di", 32'(di), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("release_first_clk", 32'(mmcm_rst), 32'd0);
        wait_done(1000, n);
        check("startup_waits_lock", 32'(n >= LOCK_DLY), 32'd1);
        check("startup_mode_cur", 32'(mode_cur), 32'd0);
        check("startup_error", 32'(error), 32'd0);
        check("startup_idle", 32'(busy), 32'd0);

        // Bad modes are rejected in IDLE; the last vector is an accepted mode-1 request.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].req && vecs[i].mode < 4'd2) begin
                mem[8] = 16'hFFFF;
                push_seq(vecs[i].mode, 24);
            end
            mode_req = vecs[i].req;
            mode     = vecs[i].mode;
            @(negedge clk);
            mode_req = 1'b0;
            check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].err));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_mmcm_rst", i), 32'(mmcm_rst), 32'(vecs[i].mrst));
            check($sformatf("vec%0d_mode_cur", i), 32'(mode_cur), 32'(vecs[i].cur));
        end
        wait_done(2000, n);
        check("m1_mode_cur", 32'(mode_cur), 32'd1);
        check("m1_reg08", 32'(mem[8]), 32'h1145);
        check("m1_all_ops", 32'(sbq.size()), 32'd0);

        // A request while busy must be dropped, not queued.
        do_req(4'd0, 24);
        repeat (20) @(negedge clk);
        mode_req = 1'b1; mode = 4'd1;
        @(negedge clk);
        mode_req = 1'b0;
        wait_done(2000, n);
        check("ignored_req_mode_cur", 32'(mode_cur), 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("ignored_req_no_rerun", 32'(n), 32'd0);
        check("ignored_req_ops", 32'(sbq.size()), 32'd0);

        // DRP never answers.
        drdy_en = 1'b0;
        do_req(4'd1, 1);
        n = 0;
        while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        repeat (55) @(negedge clk);
        check("drdy_to_not_early", 32'(error), 32'd0);
        n = 0;
        while (!error && n < 20) begin @(negedge clk); n++; end
        check("drdy_to_error", 32'(error), 32'd1);
        check("drdy_to_mmcm_rst", 32'(mmcm_rst), 32'd0);
        check("drdy_to_idle", 32'(busy), 32'd0);
        check("drdy_to_mode_cur", 32'(mode_cur), 32'd0);
        drdy_en = 1'b1;
        do_req(4'd1, 24);
        check("recover_error_clr", 32'(error), 32'd0);
        wait_done(2000, n);
        check("recover_mode_cur", 32'(mode_cur), 32'd1);

        // LOCKED never comes.
        lock_en = 1'b0;
        do_req(4'd0, 24);
        n = 0;
        while (mmcm_rst && n < 500) begin @(negedge clk); n++; end
        check("lock_to_released", 32'(mmcm_rst), 32'd0);
        n = 0;
        while (!error && n < 400) begin @(negedge clk); n++; end
        check("lock_to_cycles", 32'(n >= LOCK_TO - 2 && n <= LOCK_TO + 2), 32'd1);
        check("lock_to_mode_cur", 32'(mode_cur), 32'd1);
        check("lock_to_idle", 32'(busy), 32'd0);
        lock_en = 1'b1;

        // Async reset while a DRP write is outstanding.
        do_req(4'd1, 24);
        n = 0;
        while (!(den && dwe) && n < 100) begin @(negedge clk); n++; end
        check("found_write", 32'(den && dwe), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        check("arst_busy", 32'(busy), 32'd1);
        check("arst_den", 32'(den), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        check("arst_mode_cur", 32'(mode_cur), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_rerelease", 32'(mmcm_rst), 32'd0);
        wait_done(1000, n);
        check("arst_final_mode", 32'(mode_cur), 32'd0);
        check("arst_no_drp", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_clocks_drp_ctrl.md
Name: display_clocks_drp_ctrl

Overview:
Runtime reconfiguration sequencer for the display MMCM via its DRP port, so the pixel clock pair (1x/5x) can switch between video modes without rebuilding the bitstream (mode 0 = 640x480 25.2/126 MHz; mode 1 = 1280x720 74.25/371.25 MHz). It holds the MMCM in reset, read-modify-writes a per-mode register table, releases reset and waits for lock. It runs on the fixed board input clock, never on an MMCM output.

Parameters:
MODE_CNT, 2, number of modes in the ROM table (1-16)
MODE_W, 4, width of mode select
REGS_PER_MODE, 12, DRP table entries per mode
DRDY_TIMEOUT, 64, max cycles from DEN to DRDY before error
LOCK_TIMEOUT, 65535, max cycles from reset release to LOCKED before error

Ports:
i_clk  in  1  board input clock (100 MHz), also DRP DCLK
i_rst  in  1  reset, asynchronous, active high
i_mode_req  in  1  one-cycle request to switch mode
i_mode  in  MODE_W  requested mode, sampled with i_mode_req
o_busy  out  1  sequence in progress
o_done  out  1  one-cycle pulse: lock achieved after a sequence
o_error  out  1  sticky: timeout or bad mode; cleared by next accepted request
o_mode_cur  out  MODE_W  mode last successfully applied
o_mmcm_rst  out  1  drives MMCM RST
i_mmcm_locked  in  1  MMCM LOCKED (synchronised internally, 2 flops)
o_drp_den  out  1  DRP enable (single-cycle pulse)
o_drp_dwe  out  1  DRP write enable (valid with den)
o_drp_daddr  out  7  DRP address
o_drp_di  out  16  DRP write data
i_drp_do  in  16  DRP read data
i_drp_drdy  in  1  DRP ready

Behaviour:
- Reset values: o_mmcm_rst=1, o_busy=1, o_done=0, o_error=0, o_mode_cur=0, o_drp_den=0, o_drp_dwe=0, o_drp_daddr=0, o_drp_di=0, state=RELEASE. After reset the block releases the MMCM (bitstream config = mode 0) and waits for lock, exactly like a completed sequence.
- States: IDLE, RST_ASSERT, READ, WAIT_RD, WRITE, WAIT_WR, NEXT, RELEASE, WAIT_LOCK, DONE.
- IDLE: o_busy=0. On i_mode_req with i_mode<MODE_CNT: latch mode, idx=0, clear o_error, go to RST_ASSERT. If i_mode>=MODE_CNT: set o_error, stay in IDLE, MMCM untouched.
- RST_ASSERT: o_mmcm_rst=1; hold 4 cycles, then READ.
- READ: one-cycle den=1, dwe=0, daddr=rom.addr[idx] -> WAIT_RD.
- WAIT_RD: on drdy capture do -> WRITE. Counter > DRDY_TIMEOUT -> error path.
- WRITE: one-cycle den=1, dwe=1, di = (do & rom.keep) | (rom.data & ~rom.keep) -> WAIT_WR.
- WAIT_WR: on drdy -> NEXT; timeout -> error path.
- NEXT: idx==REGS_PER_MODE-1 -> RELEASE, else idx++ -> READ.
- RELEASE: o_mmcm_rst=0 -> WAIT_LOCK, lock counter cleared.
- WAIT_LOCK: synchronised locked=1 -> DONE; counter reaches LOCK_TIMEOUT -> error path.
- DONE: o_done=1 for one cycle, o_mode_cur=latched mode -> IDLE.
- Error path: o_error=1, den=0, o_mmcm_rst=0, o_mode_cur unchanged, -> IDLE.
- Exactly one DRP transaction outstanding; den never asserted while waiting on drdy. A drdy seen outside WAIT_RD/WAIT_WR is ignored.
- i_mode_req while o_busy=1 is ignored (no queueing).
- Async reset mid-sequence: immediate return to reset values. The MMCM stays in reset and is then re-released with partial config; the user must issue a new request. Documented, not masked.
- Counters saturate; idx width = clog2(REGS_PER_MODE).

Decomposition:
- Package display_clocks_pkg: state encoding, DRP entry fields (ADDR_W=7, DATA_W=16), the mode enum constants MODE_640X480=0 and MODE_1280X720=1.
- Sub-module display_clocks_drp_rom: combinational lookup of (mode, idx) -> {addr, keep, data}. It holds the CLKOUT0/1, CLKFBOUT, DIVCLK, lock and filter tables per mode.

Test Plan:
- Reset release with a locked model asserting 100 cycles after RST falls -> o_mmcm_rst 1->0 at the first clock, o_done pulse, o_mode_cur=0, o_error=0.
- Request mode 1 with a DRP model (drdy 3 cycles after den, reg 0x08 preloaded 0xFFFF, keep=0x1000, data=0x0145) -> 12 reads and 12 writes in order, written value 0x1145, o_mmcm_rst high throughout, then o_done and o_mode_cur=1.
- i_mode=5 -> o_error=1 the next cycle, no den, o_mmcm_rst stays 0, o_busy stays 0.
- DRP model never returns drdy -> o_error after 64 cycles, o_mmcm_rst=0, IDLE. A following valid request clears o_error and completes.
- Locked never asserts (LOCK_TIMEOUT=200 in the bench) -> o_error at cycle 200 after release, o_mode_cur unchanged.
- i_mode_req pulsed mid-sequence and async reset asserted during WAIT_WR -> the first request is ignored; on reset, outputs take reset values within the same cycle and the startup sequence reruns.
